// File: rtl/spim_xfer_if.sv
// Command/handshake bundle between the SPI transaction sequencer (master) and the
// byte shift engine spim_xfer (slave).
interface spim_xfer_if;
  logic [1:0] boper;
  logic [1:0] bmode;
  logic [7:0] tbyte;
  logic [4:0] dummy;
  logic [7:0] rbyte;
  logic       bdone;

  modport master (
    output boper,
    output bmode,
    output tbyte,
    output dummy,
    input  rbyte,
    input  bdone
  );

  modport slave (
    input  boper,
    input  bmode,
    input  tbyte,
    input  dummy,
    output rbyte,
    output bdone
  );
endinterface

// File: rtl/spim_xfer.sv
// SPI master byte shift engine: one write/read byte or a run of dummy clocks per command,
// single/dual/quad lanes. Optional SPIM_XFER_HOLDWP_EN keeps WP#/HOLD# (IO[3:2]) high.
module spim_xfer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_n,
  input  logic [1:0] ckmod,
  input  logic [7:0] ckdiv,
  spim_xfer_if.slave cmd,
  output logic       spi_ck,
  input  logic [3:0] spi_di,
  output logic [3:0] spi_do,
  output logic [3:0] spi_oe
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDummy = 2'd2;

  localparam logic [1:0] OpNone  = 2'd0;
  localparam logic [1:0] OpRead  = 2'd2;
  localparam logic [1:0] OpDummy = 2'd3;

`ifdef SPIM_XFER_HOLDWP_EN
  localparam logic [3:0] IdleLanes = 4'b1100;
`else
  localparam logic [3:0] IdleLanes = 4'b0000;
`endif

  // IO[3:2] belong to the data path only in quad mode.
  function automatic logic [3:0] wp_fix(input logic [1:0] m, input logic [3:0] v);
`ifdef SPIM_XFER_HOLDWP_EN
    return (m == 2'd3) ? v : {2'b11, v[1:0]};
`else
    return (m == 2'd3) ? v : {2'b00, v[1:0]};
`endif
  endfunction

  function automatic logic [3:0] beat_out(input logic [1:0] m, input logic rd,
                                          input logic [7:0] tx);
    logic [3:0] v;
    case (m)
      2'd3:    v = tx[7:4];
      2'd2:    v = {2'b00, tx[7:6]};
      default: v = {3'b000, tx[7]};
    endcase
    return rd ? 4'h0 : v;
  endfunction

  function automatic logic [7:0] tx_next(input logic [1:0] m, input logic [7:0] tx);
    case (m)
      2'd3:    return {tx[3:0], 4'h0};
      2'd2:    return {tx[5:0], 2'b00};
      default: return {tx[6:0], 1'b0};
    endcase
  endfunction

  function automatic logic [7:0] rx_next(input logic [1:0] m, input logic [7:0] rx,
                                         input logic [3:0] di);
    case (m)
      2'd3:    return {rx[3:0], di};
      2'd2:    return {rx[5:0], di[1:0]};
      default: return {rx[6:0], di[1]};
    endcase
  endfunction

  // Single-lane reads still drive IO0 low; dual/quad reads release every lane.
  function automatic logic [3:0] lane_oe(input logic [1:0] m, input logic rd);
    case (m)
      2'd3:    return rd ? 4'b0000 : 4'b1111;
      2'd2:    return rd ? 4'b0000 : 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [5:0] last_tog(input logic [1:0] m);
    case (m)
      2'd3:    return 6'd3;
      2'd2:    return 6'd7;
      default: return 6'd15;
    endcase
  endfunction

  logic [1:0] state_q, state_d;
  logic [7:0] hc_q, hc_d;
  logic [5:0] tog_q, tog_d;
  logic [5:0] last_q, last_d;
  logic       ck_q, ck_d;
  logic       cpha_q, cpha_d;
  logic [7:0] div_q, div_d;
  logic [1:0] mode_q, mode_d;
  logic       rd_q, rd_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rbyte_q, rbyte_d;
  logic [3:0] do_q, do_d;
  logic [3:0] oe_q, oe_d;
  logic       bdone_q, bdone_d;

  logic leading;
  logic is_last;
  logic acc_rd;

  assign leading = ~tog_q[0];
  assign is_last = (tog_q == last_q);
  assign acc_rd  = (cmd.boper == OpRead);

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    tog_d   = tog_q;
    last_d  = last_q;
    ck_d    = ck_q;
    cpha_d  = cpha_q;
    div_d   = div_q;
    mode_d  = mode_q;
    rd_d    = rd_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rbyte_d = rbyte_q;
    do_d    = do_q;
    oe_d    = oe_q;
    bdone_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd.boper != OpNone) begin
          ck_d   = ckmod[1];
          cpha_d = ckmod[0];
          div_d  = ckdiv;
          hc_d   = ckdiv;
          mode_d = cmd.bmode;
          tog_d  = 6'd0;
          rd_d   = acc_rd;
          tx_d   = cmd.tbyte;
          do_d   = wp_fix(cmd.bmode, 4'h0);
          if (cmd.boper == OpDummy) begin
            last_d = {cmd.dummy, 1'b0} - 6'd1;
            oe_d   = wp_fix(cmd.bmode, 4'h0);
            if (cmd.dummy == 5'd0) begin
              bdone_d = 1'b1;
            end else begin
              state_d = StDummy;
            end
          end else begin
            state_d = StShift;
            last_d  = last_tog(cmd.bmode);
            oe_d    = wp_fix(cmd.bmode, lane_oe(cmd.bmode, acc_rd));
            // CPHA=0 presents the first beat before the first SCK edge.
            if (!ckmod[0]) begin
              do_d = wp_fix(cmd.bmode, beat_out(cmd.bmode, acc_rd, cmd.tbyte));
              tx_d = tx_next(cmd.bmode, cmd.tbyte);
            end
          end
        end
      end
      StShift, StDummy: begin
        if (hc_q != 8'd0) begin
          hc_d = hc_q - 8'd1;
        end else begin
          ck_d  = ~ck_q;
          hc_d  = div_q;
          tog_d = tog_q + 6'd1;
          if (state_q == StShift) begin
            if (leading ^ cpha_q) begin
              rx_d = rx_next(mode_q, rx_q, spi_di);
            end
            if (cpha_q ? leading : (!leading && !is_last)) begin
              do_d = wp_fix(mode_q, beat_out(mode_q, rd_q, tx_q));
              tx_d = tx_next(mode_q, tx_q);
            end
            if (is_last && rd_q) begin
              rbyte_d = rx_d;
            end
          end
          if (is_last) begin
            state_d = StIdle;
            bdone_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (!clr_n) begin
      state_d = StIdle;
      ck_d    = ckmod[1];
      hc_d    = 8'd0;
      tog_d   = 6'd0;
      do_d    = IdleLanes;
      oe_d    = IdleLanes;
      rbyte_d = rbyte_q;
      bdone_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hc_q    <= 8'd0;
      tog_q   <= 6'd0;
      last_q  <= 6'd0;
      ck_q    <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= 8'd0;
      mode_q  <= 2'd0;
      rd_q    <= 1'b0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      rbyte_q <= 8'd0;
      do_q    <= IdleLanes;
      oe_q    <= IdleLanes;
      bdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      tog_q   <= tog_d;
      last_q  <= last_d;
      ck_q    <= ck_d;
      cpha_q  <= cpha_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      rd_q    <= rd_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rbyte_q <= rbyte_d;
      do_q    <= do_d;
      oe_q    <= oe_d;
      bdone_q <= bdone_d;
    end
  end

  assign spi_ck    = ck_q;
  assign spi_do    = do_q;
  assign spi_oe    = oe_q;
  assign cmd.rbyte = rbyte_q;
  assign cmd.bdone = bdone_q;

endmodule

// File: tb/tb_spim_xfer.sv
// Directed bench for spim_xfer: write/read/dummy commands in each lane mode, back-to-back,
// soft clear and asynchronous reset, all against hand-computed expectations.
module tb_spim_xfer;

  logic       clk;
  logic       rst_n;
  logic       clr_n;
  logic [1:0] ckmod;
  logic [7:0] ckdiv;
  logic       spi_ck;
  logic [3:0] spi_di;
  logic [3:0] spi_do;
  logic [3:0] spi_oe;

  int n_checks;
  int n_pass;

  spim_xfer_if cmd_if ();

  spim_xfer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_n  (clr_n),
    .ckmod  (ckmod),
    .ckdiv  (ckdiv),
    .cmd    (cmd_if.slave),
    .spi_ck (spi_ck),
    .spi_di (spi_di),
    .spi_do (spi_do),
    .spi_oe (spi_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command at the next edge (caller is just after an edge) and follows it until
  // bdone. lat counts clk edges after the accept edge; do_rise packs spi_do seen after each
  // SCK rising edge, one nibble per edge; di_seq supplies one nibble per sampling SCK edge.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] mode, input logic [1:0] ckm,
                         input logic [7:0] div, input logic [7:0] tb, input logic [4:0] dm,
                         input logic [31:0] di_seq, output int lat, output int rises,
                         output logic [31:0] do_rise, output logic [3:0] oe_or,
                         output int first_tog);
    logic [31:0] seq;
    logic        prev_ck;
    int          togs;
    seq          = di_seq;
    spi_di       = seq[31:28];
    ckmod        = ckm;
    ckdiv        = div;
    cmd_if.boper = op;
    cmd_if.bmode = mode;
    cmd_if.tbyte = tb;
    cmd_if.dummy = dm;
    @(posedge clk);
    #1;
    // Scramble the inputs so any unlatched use shows up.
    cmd_if.boper = 2'd0;
    cmd_if.bmode = ~mode;
    cmd_if.tbyte = ~tb;
    cmd_if.dummy = ~dm;
    ckdiv        = div + 8'd3;
    ckmod[0]     = ~ckm[0];
    lat = 0; rises = 0; do_rise = 32'h0; oe_or = 4'h0; first_tog = 0; togs = 0;
    prev_ck = spi_ck;
    while (!cmd_if.bdone && lat < 600) begin
      oe_or |= spi_oe;
      @(posedge clk);
      #1;
      lat++;
      if (spi_ck != prev_ck) begin
        togs++;
        if (first_tog == 0) first_tog = lat;
        if (spi_ck) begin
          rises++;
          do_rise = {do_rise[27:0], spi_do};
        end
        if ((togs % 2 == 1) != ckm[0]) begin
          seq    = seq << 4;
          spi_di = seq[31:28];
        end
        prev_ck = spi_ck;
      end
    end
    if (lat >= 600) check_eq("bdone_timeout", {31'h0, cmd_if.bdone}, 32'h1);
  endtask

  int          lat;
  int          rises;
  int          ftog;
  int          bad;
  logic [31:0] dor;
  logic [3:0]  oeo;
  logic        pck;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    clr_n    = 1'b1;
    ckmod    = 2'd0;
    ckdiv    = 8'd0;
    spi_di   = 4'h0;
    cmd_if.boper = 2'd0;
    cmd_if.bmode = 2'd0;
    cmd_if.tbyte = 8'h00;
    cmd_if.dummy = 5'd0;
    #3;
    check_eq("rst_ck", {31'h0, spi_ck}, 32'h0);
    check_eq("rst_do", {28'h0, spi_do}, 32'h0);
    check_eq("rst_oe", {28'h0, spi_oe}, 32'h0);
    check_eq("rst_rbyte", {24'h0, cmd_if.rbyte}, 32'h0);
    check_eq("rst_bdone", {31'h0, cmd_if.bdone}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write 0xA5, mode 0, ckdiv 1: 16 toggles of 2 clocks each.
    run_cmd(2'd1, 2'd0, 2'd0, 8'd1, 8'hA5, 5'd0, 32'h0, lat, rises, dor, oeo, ftog);
    check_eq("sw_lat", lat, 32);
    check_eq("sw_rises", rises, 8);
    check_eq("sw_bits", dor, 32'h1010_0101);
    check_eq("sw_oe", {28'h0, oeo}, 32'h1);
    check_eq("sw_ck_idle", {31'h0, spi_ck}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("sw_bdone_pulse", {31'h0, cmd_if.bdone}, 32'h0);

    // Quad read, mode 3, ckdiv 0: nibbles C then 3 sampled on trailing (rising) edges.
    run_cmd(2'd2, 2'd3, 2'd3, 8'd0, 8'h00, 5'd0, 32'hC300_0000, lat, rises, dor, oeo, ftog);
    check_eq("qr_lat", lat, 4);
    check_eq("qr_rbyte", {24'h0, cmd_if.rbyte}, 32'hC3);
    check_eq("qr_oe", {28'h0, oeo}, 32'h0);
    check_eq("qr_ck_idle", {31'h0, spi_ck}, 32'h1);
    @(posedge clk);
    #1;

    // Single read 0x96 from IO1; other IO bits carry noise opposite to IO1.
    run_cmd(2'd2, 2'd1, 2'd0, 8'd0, 8'h00, 5'd0, 32'h2DD2_D22D, lat, rises, dor, oeo, ftog);
    check_eq("sr_lat", lat, 16);
    check_eq("sr_rbyte", {24'h0, cmd_if.rbyte}, 32'h96);
    check_eq("sr_oe", {28'h0, oeo}, 32'h1);
    check_eq("sr_do_low", dor, 32'h0);
    @(posedge clk);
    #1;

    // Dual write 0x1B, then a single write 0x3C issued in the bdone cycle.
    run_cmd(2'd1, 2'd2, 2'd0, 8'd0, 8'h1B, 5'd0, 32'h0, lat, rises, dor, oeo, ftog);
    check_eq("dw_lat", lat, 8);
    check_eq("dw_bits", dor, 32'h0000_0123);
    check_eq("dw_oe", {28'h0, oeo}, 32'h3);
    check_eq("dw_bdone", {31'h0, cmd_if.bdone}, 32'h1);
    run_cmd(2'd1, 2'd0, 2'd0, 8'd0, 8'h3C, 5'd0, 32'h0, lat, rises, dor, oeo, ftog);
    check_eq("b2b_first_tog", ftog, 1);
    check_eq("b2b_lat", lat, 16);
    check_eq("b2b_bits", dor, 32'h0011_1100);
    check_eq("b2b_oe", {28'h0, oeo}, 32'h1);
    @(posedge clk);
    #1;

    // Dummy 5 cycles at ckdiv 2: 10 toggles x 3 clocks.
    run_cmd(2'd3, 2'd0, 2'd0, 8'd2, 8'h00, 5'd5, 32'h0, lat, rises, dor, oeo, ftog);
    check_eq("dm5_lat", lat, 30);
    check_eq("dm5_rises", rises, 5);
    check_eq("dm5_oe", {28'h0, oeo}, 32'h0);
    @(posedge clk);
    #1;

    // Dummy 0: bdone directly after the accept edge, no SCK activity.
    run_cmd(2'd3, 2'd0, 2'd0, 8'd4, 8'h00, 5'd0, 32'h0, lat, rises, dor, oeo, ftog);
    check_eq("dm0_lat", lat, 0);
    check_eq("dm0_bdone", {31'h0, cmd_if.bdone}, 32'h1);
    check_eq("dm0_ck", {31'h0, spi_ck}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("dm0_pulse", {31'h0, cmd_if.bdone}, 32'h0);
    check_eq("dm0_no_tog", {31'h0, spi_ck}, 32'h0);

    // Soft clear after three SCK edges of a single write.
    ckmod = 2'd0; ckdiv = 8'd1;
    cmd_if.boper = 2'd1; cmd_if.bmode = 2'd0; cmd_if.tbyte = 8'hA5;
    @(posedge clk);
    #1;
    cmd_if.boper = 2'd0;
    bad = 0; lat = 0; pck = spi_ck;
    while (bad < 3 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (spi_ck != pck) bad++;
      pck = spi_ck;
    end
    check_eq("clr_pre_ck", {31'h0, spi_ck}, 32'h1);
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    check_eq("clr_ck", {31'h0, spi_ck}, 32'h0);
    check_eq("clr_oe", {28'h0, spi_oe}, 32'h0);
    check_eq("clr_do", {28'h0, spi_do}, 32'h0);
    check_eq("clr_bdone", {31'h0, cmd_if.bdone}, 32'h0);
    check_eq("clr_rbyte", {24'h0, cmd_if.rbyte}, 32'h96);
    bad = 0; pck = spi_ck;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (spi_ck != pck || cmd_if.bdone) bad++;
      pck = spi_ck;
    end
    check_eq("clr_idle", bad, 0);
    run_cmd(2'd1, 2'd0, 2'd0, 8'd1, 8'h5A, 5'd0, 32'h0, lat, rises, dor, oeo, ftog);
    check_eq("post_clr_lat", lat, 32);
    check_eq("post_clr_bits", dor, 32'h0101_1010);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a quad read.
    ckmod = 2'd3; ckdiv = 8'd3;
    cmd_if.boper = 2'd2; cmd_if.bmode = 2'd3;
    @(posedge clk);
    #1;
    cmd_if.boper = 2'd0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("mid_ck", {31'h0, spi_ck}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_ck", {31'h0, spi_ck}, 32'h0);
    check_eq("arst_do", {28'h0, spi_do}, 32'h0);
    check_eq("arst_oe", {28'h0, spi_oe}, 32'h0);
    check_eq("arst_rbyte", {24'h0, cmd_if.rbyte}, 32'h0);
    check_eq("arst_bdone", {31'h0, cmd_if.bdone}, 32'h0);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
